// File: rtl/multi_stage_alu_seq_if.sv
// Operand/control bus between the control FSM and the multi-stage ALU.
// RES is a plain tri-state port on the ALU and is not part of this interface.
interface multi_stage_alu_seq_if #(
    parameter int unsigned N = 10
);
    logic [N-1:0] OP;
    logic [3:0]   FN;
    logic         Ain;
    logic         Gin;
    logic         Gout;
    logic         START;
    logic         BUSY;
    logic         DONE;
    logic [3:0]   FLAGS;

    modport master (
        output OP, FN, Ain, Gin, Gout, START,
        input  BUSY, DONE, FLAGS
    );

    modport slave (
        input  OP, FN, Ain, Gin, Gout, START,
        output BUSY, DONE, FLAGS
    );
endinterface

// File: rtl/multi_stage_alu_seq.sv
// Multi-stage ALU with A/G latches and a tri-state result drive.
// Single-cycle ops are captured by Gin; MUL/DIV/MOD iterate under a START/BUSY/DONE handshake.
module multi_stage_alu_seq #(
    parameter int unsigned N  = 10,
    parameter int unsigned CW = $clog2(N + 1)
) (
    input  logic                  CLKb,
    input  logic                  RST,
    multi_stage_alu_seq_if.slave  bus,
    output wire  [N-1:0]          RES
);

    localparam logic [3:0] FN_ADD = 4'b0010;
    localparam logic [3:0] FN_SUB = 4'b0011;
    localparam logic [3:0] FN_INV = 4'b0100;
    localparam logic [3:0] FN_FLP = 4'b0101;
    localparam logic [3:0] FN_AND = 4'b0110;
    localparam logic [3:0] FN_OR  = 4'b0111;
    localparam logic [3:0] FN_XOR = 4'b1000;
    localparam logic [3:0] FN_LSL = 4'b1001;
    localparam logic [3:0] FN_LSR = 4'b1010;
    localparam logic [3:0] FN_ASR = 4'b1011;
    localparam logic [3:0] FN_MUL = 4'b1100;
    localparam logic [3:0] FN_DIV = 4'b1101;
    localparam logic [3:0] FN_MOD = 4'b1110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_busy;
    logic             r_done;
    logic [N-1:0]     r_a;
    logic [N-1:0]     r_b;
    logic [N-1:0]     r_g;
    logic [3:0]       r_flags;
    logic [3:0]       r_fn;
    logic [CW-1:0]    r_cnt;
    logic [2*N-1:0]   r_acc;

    logic             w_fn_multi;
    logic [N:0]       w_add;
    logic [N:0]       w_sub;
    logic [N:0]       w_lsl;
    logic [N:0]       w_lsr;
    logic [N:0]       w_asr;
    logic signed [N:0] w_asr_in;
    logic [N-1:0]     w_res;
    logic             w_c;
    logic             w_v;
    logic             w_sc_ok;

    logic [N:0]       w_mul_sum;
    logic [2*N-1:0]   w_mul_step;
    logic [N:0]       w_div_sh;
    logic [N:0]       w_div_sub;
    logic             w_div_ge;
    logic [N-1:0]     w_rem_nxt;
    logic [2*N-1:0]   w_div_step;
    logic [N-1:0]     w_mc_res;
    logic             w_mc_v;

    assign w_fn_multi = (bus.FN == FN_MUL) || (bus.FN == FN_DIV) || (bus.FN == FN_MOD);

    // Single-cycle result from A and the live bus; shifts carry the last bit out in the extra LSB/MSB.
    always_comb begin
        w_add    = {1'b0, r_a} + {1'b0, bus.OP};
        w_sub    = {1'b0, r_a} - {1'b0, bus.OP};
        w_lsl    = {1'b0, r_a} << bus.OP;
        w_lsr    = {r_a, 1'b0} >> bus.OP;
        w_asr_in = {r_a, 1'b0};
        w_asr    = w_asr_in >>> bus.OP;
        w_res    = '0;
        w_c      = 1'b0;
        w_v      = 1'b0;
        w_sc_ok  = 1'b1;
        case (bus.FN)
            FN_ADD: begin
                w_res = w_add[N-1:0];
                w_c   = w_add[N];
                w_v   = (r_a[N-1] == bus.OP[N-1]) && (w_add[N-1] != r_a[N-1]);
            end
            FN_SUB: begin
                w_res = w_sub[N-1:0];
                w_c   = w_sub[N];
                w_v   = (r_a[N-1] != bus.OP[N-1]) && (w_sub[N-1] != r_a[N-1]);
            end
            FN_INV: w_res = ~r_a + N'(1);
            FN_FLP: w_res = ~r_a;
            FN_AND: w_res = r_a & bus.OP;
            FN_OR:  w_res = r_a | bus.OP;
            FN_XOR: w_res = r_a ^ bus.OP;
            FN_LSL: begin
                w_res = w_lsl[N-1:0];
                w_c   = w_lsl[N];
            end
            FN_LSR: begin
                w_res = w_lsr[N:1];
                w_c   = w_lsr[0];
            end
            FN_ASR: begin
                w_res = w_asr[N:1];
                w_c   = w_asr[0];
            end
            default: w_sc_ok = 1'b0;
        endcase
    end

    // One shift-add step (acc = {hi, multiplier}) and one restoring-divide step (acc = {rem, quotient}).
    always_comb begin
        w_mul_sum  = {1'b0, r_acc[2*N-1:N]} + (r_acc[0] ? {1'b0, r_a} : '0);
        w_mul_step = {w_mul_sum, r_acc[N-1:1]};
        w_div_sh   = {r_acc[2*N-1:N], r_acc[N-1]};
        w_div_ge   = (w_div_sh >= {1'b0, r_b});
        w_div_sub  = w_div_sh - {1'b0, r_b};
        w_rem_nxt  = w_div_ge ? w_div_sub[N-1:0] : w_div_sh[N-1:0];
        w_div_step = {w_rem_nxt, r_acc[N-2:0], w_div_ge};
    end

    always_comb begin
        w_mc_res = r_acc[N-1:0];
        w_mc_v   = 1'b0;
        case (r_fn)
            FN_MUL: w_mc_v = |r_acc[2*N-1:N];
            FN_DIV: w_mc_v = (r_b == '0);
            FN_MOD: begin
                w_mc_res = r_acc[2*N-1:N];
                w_mc_v   = (r_b == '0);
            end
            default: ;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (bus.START && w_fn_multi) w_state_nxt = S_RUN;
            S_RUN:   if (r_cnt == '0) w_state_nxt = S_FIN;
            S_FIN:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(negedge CLKb) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == S_RUN);
            r_done  <= (w_state_nxt == S_FIN);
        end
    end

    // Datapath registers; A and G are only writable outside RUN.
    always_ff @(negedge CLKb) begin
        if (RST) begin
            r_a     <= '0;
            r_b     <= '0;
            r_g     <= '0;
            r_flags <= '0;
            r_fn    <= '0;
            r_cnt   <= '0;
            r_acc   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.Ain) r_a <= bus.OP;
                    if (bus.START && w_fn_multi) begin
                        r_b   <= bus.OP;
                        r_fn  <= bus.FN;
                        r_cnt <= CW'(N);
                        r_acc <= (bus.FN == FN_MUL) ? {{N{1'b0}}, bus.OP} : {{N{1'b0}}, r_a};
                    end else if (bus.Gin && w_sc_ok) begin
                        r_g     <= w_res;
                        r_flags <= {w_res == '0, w_res[N-1], w_c, w_v};
                    end
                end
                S_RUN: begin
                    if (r_cnt != '0) begin
                        r_acc <= (r_fn == FN_MUL) ? w_mul_step : w_div_step;
                        r_cnt <= r_cnt - CW'(1);
                    end else begin
                        r_g     <= w_mc_res;
                        r_flags <= {w_mc_res == '0, w_mc_res[N-1], 1'b0, w_mc_v};
                    end
                end
                S_FIN: begin
                    if (bus.Ain) r_a <= bus.OP;
                end
                default: ;
            endcase
        end
    end

    assign bus.BUSY  = r_busy;
    assign bus.DONE  = r_done;
    assign bus.FLAGS = r_flags;
    assign RES       = bus.Gout ? r_g : 'z;

endmodule

// File: tb/tb_multi_stage_alu_seq.sv
// Directed bench for multi_stage_alu_seq: driver pushes expected G/FLAGS into a scoreboard,
// a monitor pops and compares whenever a Gin capture or a DONE pulse becomes visible.
module tb_multi_stage_alu_seq;
    localparam int unsigned N = 10;

    localparam logic [3:0] ADD = 4'b0010;
    localparam logic [3:0] SUB = 4'b0011;
    localparam logic [3:0] INV = 4'b0100;
    localparam logic [3:0] FLP = 4'b0101;
    localparam logic [3:0] AND = 4'b0110;
    localparam logic [3:0] OR  = 4'b0111;
    localparam logic [3:0] XOR = 4'b1000;
    localparam logic [3:0] LSL = 4'b1001;
    localparam logic [3:0] LSR = 4'b1010;
    localparam logic [3:0] ASR = 4'b1011;
    localparam logic [3:0] MUL = 4'b1100;
    localparam logic [3:0] DIV = 4'b1101;
    localparam logic [3:0] MOD = 4'b1110;

    typedef struct packed {
        logic [N-1:0] g;
        logic [3:0]   f;
    } exp_t;

    logic         CLKb = 1'b1;
    logic         RST;
    wire  [N-1:0] res;

    multi_stage_alu_seq_if #(.N(N)) bus ();
    multi_stage_alu_seq #(.N(N)) dut (
        .CLKb (CLKb),
        .RST  (RST),
        .bus  (bus),
        .RES  (res)
    );

    always #5 CLKb = ~CLKb;

    exp_t  sb_q[$];
    string sb_name[$];
    int    n_checks = 0;
    int    n_pass   = 0;
    logic  gin_chk  = 1'b0;
    logic  gin_q    = 1'b0;

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endfunction

    // A Gin the driver expects to take effect is visible on RES one half-cycle after its edge.
    always @(negedge CLKb) gin_q <= gin_chk;

    always @(posedge CLKb) begin
        exp_t  e;
        string nm;
        if (!RST && (gin_q || bus.DONE === 1'b1)) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_output", 32'(1), 32'(0));
            end else begin
                e  = sb_q.pop_front();
                nm = sb_name.pop_front();
                check({nm, "_res"},   32'(res),       32'(e.g));
                check({nm, "_flags"}, 32'(bus.FLAGS), 32'(e.f));
            end
        end
    end

    task automatic tick();
        @(negedge CLKb);
        #1;
    endtask

    task automatic push_exp(input string nm, input logic [N-1:0] g, input logic [3:0] f);
        exp_t e;
        e.g = g;
        e.f = f;
        sb_q.push_back(e);
        sb_name.push_back(nm);
    endtask

    task automatic load_a(input logic [N-1:0] a);
        bus.OP  = a;
        bus.Ain = 1'b1;
        tick();
        bus.Ain = 1'b0;
    endtask

    task automatic sc_run(input string nm, input logic [3:0] fn, input logic [N-1:0] op,
                          input logic [N-1:0] g, input logic [3:0] f);
        bus.FN  = fn;
        bus.OP  = op;
        bus.Gin = 1'b1;
        gin_chk = 1'b1;
        push_exp(nm, g, f);
        tick();
        bus.Gin = 1'b0;
        gin_chk = 1'b0;
        tick();
    endtask

    task automatic sc_op(input string nm, input logic [N-1:0] a, input logic [3:0] fn,
                         input logic [N-1:0] op, input logic [N-1:0] g, input logic [3:0] f);
        load_a(a);
        sc_run(nm, fn, op, g, f);
    endtask

    task automatic wait_done(input string nm, input int start_cnt);
        int cnt;
        cnt = start_cnt;
        while (bus.DONE !== 1'b1 && cnt < 4 * N) begin
            tick();
            cnt++;
        end
        check({nm, "_latency"}, 32'(cnt), 32'(N + 1));
    endtask

    task automatic mc_op(input string nm, input logic [N-1:0] a, input logic [3:0] fn,
                         input logic [N-1:0] b, input logic [N-1:0] g, input logic [3:0] f);
        load_a(a);
        bus.FN    = fn;
        bus.OP    = b;
        bus.START = 1'b1;
        push_exp(nm, g, f);
        tick();
        bus.START = 1'b0;
        check({nm, "_busy"}, 32'(bus.BUSY), 32'(1));
        wait_done(nm, 0);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic done_seen;
        RST       = 1'b1;
        bus.OP    = '0;
        bus.FN    = '0;
        bus.Ain   = 1'b0;
        bus.Gin   = 1'b0;
        bus.Gout  = 1'b1;
        bus.START = 1'b0;
        tick();
        tick();
        RST = 1'b0;
        check("reset_res",   32'(res),       32'(0));
        check("reset_flags", 32'(bus.FLAGS), 32'(0));
        check("reset_busy",  32'(bus.BUSY),  32'(0));
        check("reset_done",  32'(bus.DONE),  32'(0));

        // single-cycle ops; flags are {Z,Nf,C,V}
        sc_op("add_wrap",   10'd1023, ADD, 10'd1,  10'd0,    4'b1010);
        sc_op("sub_ovf",    10'd512,  SUB, 10'd1,  10'd511,  4'b0001);
        sc_op("sub_borrow", 10'd3,    SUB, 10'd5,  10'd1022, 4'b0110);
        sc_op("asr3",       10'd512,  ASR, 10'd3,  10'd960,  4'b0100);
        sc_op("lsl12",      10'd512,  LSL, 10'd12, 10'd0,    4'b1000);
        sc_op("lsl_n",      10'd1,    LSL, 10'd10, 10'd0,    4'b1010);
        sc_op("lsr1",       10'd515,  LSR, 10'd1,  10'd257,  4'b0010);
        sc_op("asr12",      10'd512,  ASR, 10'd12, 10'd1023, 4'b0110);
        sc_op("and",        10'd1008, AND, 10'd255, 10'd240, 4'b0000);
        sc_op("or",         10'd1008, OR,  10'd255, 10'd1023, 4'b0100);
        sc_op("xor",        10'd1008, XOR, 10'd255, 10'd783, 4'b0100);
        sc_op("inv",        10'd1,    INV, 10'd0,  10'd1023, 4'b0100);
        sc_op("flp",        10'd0,    FLP, 10'd0,  10'd1023, 4'b0100);
        sc_op("asr0",       10'd512,  ASR, 10'd0,  10'd512,  4'b0100);
        sc_run("undef_fn",        4'b0000, 10'd7, 10'd512, 4'b0100);
        sc_run("mul_gin_ignored", MUL,     10'd3, 10'd512, 4'b0100);

        // multi-cycle ops
        mc_op("mul_25x30",  10'd25,   MUL, 10'd30, 10'd750,  4'b0100);
        mc_op("mul_40x30",  10'd40,   MUL, 10'd30, 10'd176,  4'b0001);
        mc_op("div_1000_7", 10'd1000, DIV, 10'd7,  10'd142,  4'b0000);
        mc_op("mod_1000_7", 10'd1000, MOD, 10'd7,  10'd6,    4'b0000);
        mc_op("div_by0",    10'd100,  DIV, 10'd0,  10'd1023, 4'b0101);
        mc_op("mod_by0",    10'd100,  MOD, 10'd0,  10'd100,  4'b0001);

        // hazards while a MUL is running
        load_a(10'd25);
        bus.FN    = MUL;
        bus.OP    = 10'd30;
        bus.START = 1'b1;
        push_exp("hz_mul", 10'd750, 4'b0100);
        tick();
        bus.START = 1'b0;
        repeat (3) tick();
        bus.OP    = 10'd999;
        bus.FN    = ADD;
        bus.Ain   = 1'b1;
        bus.Gin   = 1'b1;
        bus.START = 1'b1;
        tick();
        bus.Ain   = 1'b0;
        bus.Gin   = 1'b0;
        bus.START = 1'b0;
        check("hz_res_frozen", 32'(res),      32'(100));
        check("hz_busy",       32'(bus.BUSY), 32'(1));
        wait_done("hz_mul", 4);
        bus.FN    = MUL;
        bus.OP    = 10'd5;
        bus.START = 1'b1;
        tick();
        bus.START = 1'b0;
        check("fin_start_ignored", 32'(bus.BUSY), 32'(0));
        check("fin_g_kept",        32'(res),      32'(750));
        sc_run("hz_a_frozen", ADD, 10'd0, 10'd25, 4'b0000);
        bus.FN    = ADD;
        bus.START = 1'b1;
        tick();
        bus.START = 1'b0;
        check("start_add_ignored", 32'(bus.BUSY), 32'(0));

        // reset in the middle of a MUL
        load_a(10'd25);
        bus.FN    = MUL;
        bus.OP    = 10'd30;
        bus.START = 1'b1;
        tick();
        bus.START = 1'b0;
        repeat (5) tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("rst_busy",  32'(bus.BUSY),  32'(0));
        check("rst_done",  32'(bus.DONE),  32'(0));
        check("rst_res",   32'(res),       32'(0));
        check("rst_flags", 32'(bus.FLAGS), 32'(0));
        done_seen = 1'b0;
        repeat (N + 4) begin
            tick();
            if (bus.DONE === 1'b1) done_seen = 1'b1;
        end
        check("rst_no_done", 32'(done_seen), 32'(0));
        mc_op("post_rst_mul", 10'd25, MUL, 10'd30, 10'd750, 4'b0100);

        repeat (3) tick();
        check("sb_drained", 32'(sb_q.size()), 32'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
